// File: rtl/ch3_wt_pkg.sv
// Shared definitions for the CH3 watch timekeeping core: FSM encodings, field width,
// default limits and the wrap-increment helper used by all three time fields.
package ch3_wt_pkg;

    localparam int WT_W       = 7;
    localparam int SEC_MAX_D  = 59;
    localparam int MIN_MAX_D  = 59;
    localparam int HOUR_MAX_D = 23;

    // State encodings double as the SET_SEL display code.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10,
        ST_SET_S = 2'b11
    } wt_state_e;

    // Anything at or above the limit is treated as the limit, so it wraps to zero.
    function automatic logic wt_at_max(input logic [WT_W-1:0] v, input logic [WT_W-1:0] max);
        return (v >= max);
    endfunction

    function automatic logic [WT_W-1:0] wt_wrap_inc(input logic [WT_W-1:0] v,
                                                    input logic [WT_W-1:0] max);
        return wt_at_max(v, max) ? '0 : v + WT_W'(1);
    endfunction

endpackage

// File: rtl/ch3_wt_edge.sv
// Rising-edge detector for a debounced, CLK-synchronous key level. History resets to 1
// so a key already held when reset releases does not produce an edge.
module ch3_wt_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_edge
);

    logic r_key_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_d <= 1'b1;
        end else begin
            r_key_d <= i_key;
        end
    end

    assign o_edge = i_key & ~r_key_d;

endmodule

// File: rtl/ch3_wt_time_counter.sv
// CH3 watch timekeeping core: seconds/minutes/hours counted from a 1 Hz tick, with a
// MODE/INC key-driven set mode that selects and bumps one field at a time.
module ch3_wt_time_counter
    import ch3_wt_pkg::*;
#(
    parameter int SEC_MAX  = SEC_MAX_D,
    parameter int MIN_MAX  = MIN_MAX_D,
    parameter int HOUR_MAX = HOUR_MAX_D
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            TICK_1HZ,
    input  logic            MODE_KEY,
    input  logic            INC_KEY,
    output logic [WT_W-1:0] SEC,
    output logic [WT_W-1:0] MIN,
    output logic [WT_W-1:0] HOUR,
    output logic [1:0]      SET_SEL,
    output logic            DAY_CARRY
);

    localparam logic [WT_W-1:0] L_SEC_MAX  = WT_W'(SEC_MAX);
    localparam logic [WT_W-1:0] L_MIN_MAX  = WT_W'(MIN_MAX);
    localparam logic [WT_W-1:0] L_HOUR_MAX = WT_W'(HOUR_MAX);

    logic w_mode_edge;
    logic w_inc_edge;

    wt_state_e       r_state, w_state_nx;
    logic [WT_W-1:0] r_sec, w_sec_nx;
    logic [WT_W-1:0] r_min, w_min_nx;
    logic [WT_W-1:0] r_hour, w_hour_nx;
    logic            r_day_carry, w_day_carry_nx;

    ch3_wt_edge u_mode_edge (
        .clk    (CLK),
        .rst_n  (RESETN),
        .i_key  (MODE_KEY),
        .o_edge (w_mode_edge)
    );

    ch3_wt_edge u_inc_edge (
        .clk    (CLK),
        .rst_n  (RESETN),
        .i_key  (INC_KEY),
        .o_edge (w_inc_edge)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= ST_RUN;
            r_sec       <= '0;
            r_min       <= '0;
            r_hour      <= '0;
            r_day_carry <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sec       <= w_sec_nx;
            r_min       <= w_min_nx;
            r_hour      <= w_hour_nx;
            r_day_carry <= w_day_carry_nx;
        end
    end

    // A MODE edge always takes priority over INC; in RUN the tick still lands in that cycle.
    always_comb begin
        w_state_nx     = r_state;
        w_sec_nx       = r_sec;
        w_min_nx       = r_min;
        w_hour_nx      = r_hour;
        w_day_carry_nx = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (TICK_1HZ) begin
                    w_sec_nx = wt_wrap_inc(r_sec, L_SEC_MAX);
                    if (wt_at_max(r_sec, L_SEC_MAX)) begin
                        w_min_nx = wt_wrap_inc(r_min, L_MIN_MAX);
                        if (wt_at_max(r_min, L_MIN_MAX)) begin
                            w_hour_nx = wt_wrap_inc(r_hour, L_HOUR_MAX);
                            w_day_carry_nx = wt_at_max(r_hour, L_HOUR_MAX);
                        end
                    end
                end
                if (w_mode_edge) begin
                    w_state_nx = ST_SET_H;
                end
            end
            ST_SET_H: begin
                if (w_mode_edge) begin
                    w_state_nx = ST_SET_M;
                end else if (w_inc_edge) begin
                    w_hour_nx = wt_wrap_inc(r_hour, L_HOUR_MAX);
                end
            end
            ST_SET_M: begin
                if (w_mode_edge) begin
                    w_state_nx = ST_SET_S;
                end else if (w_inc_edge) begin
                    w_min_nx = wt_wrap_inc(r_min, L_MIN_MAX);
                end
            end
            ST_SET_S: begin
                // Restart the newly set time on a whole second.
                if (w_mode_edge) begin
                    w_state_nx = ST_RUN;
                    w_sec_nx   = '0;
                end else if (w_inc_edge) begin
                    w_sec_nx = wt_wrap_inc(r_sec, L_SEC_MAX);
                end
            end
            default: begin
                w_state_nx = ST_RUN;
            end
        endcase
    end

    assign SEC       = r_sec;
    assign MIN       = r_min;
    assign HOUR      = r_hour;
    assign SET_SEL   = r_state;
    assign DAY_CARRY = r_day_carry;

endmodule

// File: tb/tb_ch3_wt_time_counter.sv
// Scoreboard bench for the CH3 watch timekeeping core: a behavioural model predicts
// each cycle's outputs, which are queued on drive and compared after the clock edge.
module tb_ch3_wt_time_counter;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       TICK_1HZ;
    logic       MODE_KEY;
    logic       INC_KEY;
    logic [6:0] SEC;
    logic [6:0] MIN;
    logic [6:0] HOUR;
    logic [1:0] SET_SEL;
    logic       DAY_CARRY;

    ch3_wt_time_counter dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .TICK_1HZ  (TICK_1HZ),
        .MODE_KEY  (MODE_KEY),
        .INC_KEY   (INC_KEY),
        .SEC       (SEC),
        .MIN       (MIN),
        .HOUR      (HOUR),
        .SET_SEL   (SET_SEL),
        .DAY_CARRY (DAY_CARRY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int s;
        int m;
        int h;
        int sel;
        int c;
    } exp_t;

    exp_t  q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string cur   = "init";

    // model state
    int md_s, md_m, md_h, md_st, md_c;
    int md_pm, md_pi;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d expected %0d", cur, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_s = 0; md_m = 0; md_h = 0; md_st = 0; md_c = 0;
        md_pm = 1; md_pi = 1;
        q.delete();
    endtask

    // Runs on total seconds of the day so wrap/carry are derived independently of field logic.
    task automatic model_step(input int t, input int mk, input int ik);
        int me, ie, tot;
        exp_t e;
        me = mk & ~md_pm;
        ie = ik & ~md_pi;
        md_pm = mk;
        md_pi = ik;
        md_c = 0;
        if (md_st == 0) begin
            if (t != 0) begin
                tot = md_h * 3600 + md_m * 60 + md_s + 1;
                if (tot == 86400) begin
                    tot = 0;
                    md_c = 1;
                end
                md_h = tot / 3600;
                md_m = (tot / 60) % 60;
                md_s = tot % 60;
            end
        end else if (me == 0 && ie != 0) begin
            case (md_st)
                1: md_h = (md_h + 1) % 24;
                2: md_m = (md_m + 1) % 60;
                default: md_s = (md_s + 1) % 60;
            endcase
        end
        if (me != 0) begin
            if (md_st == 3) md_s = 0;
            md_st = (md_st + 1) % 4;
        end
        e.s = md_s; e.m = md_m; e.h = md_h; e.sel = md_st; e.c = md_c;
        q.push_back(e);
    endtask

    task automatic step(input logic t, input logic mk, input logic ik);
        exp_t e;
        TICK_1HZ = t;
        MODE_KEY = mk;
        INC_KEY  = ik;
        model_step(int'(t), int'(mk), int'(ik));
        @(posedge CLK);
        #1;
        if (q.size() == 0) begin
            chk("queue", 0, 1);
        end else begin
            e = q.pop_front();
            chk("sec",   int'(SEC),       e.s);
            chk("min",   int'(MIN),       e.m);
            chk("hour",  int'(HOUR),      e.h);
            chk("sel",   int'(SET_SEL),   e.sel);
            chk("carry", int'(DAY_CARRY), e.c);
        end
    endtask

    task automatic press_mode();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        cur = tag;
        chk("sec",   int'(SEC),       0);
        chk("min",   int'(MIN),       0);
        chk("hour",  int'(HOUR),      0);
        chk("sel",   int'(SET_SEL),   0);
        chk("carry", int'(DAY_CARRY), 0);
    endtask

    initial begin
        RESETN   = 1'b0;
        TICK_1HZ = 1'b0;
        MODE_KEY = 1'b1;
        INC_KEY  = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;

        // 1: key held through reset release gives no edge
        check_zero("reset");
        cur = "held_mode";
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // 2: preload 23:59:58 and roll the day over
        cur = "preload";
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        press_mode();
        ticks(58);
        cur = "rollover";
        ticks(2);
        step(1'b0, 1'b0, 1'b0);

        // 3: hour set wraps at 23, ticks frozen
        cur = "set_hour";
        press_mode();
        press_inc(25);
        ticks(3);

        // 4: minute wrap without carry, seconds cleared on exit (tick in exit cycle ignored)
        cur = "set_min";
        press_mode();
        press_inc(59);
        press_inc(1);
        cur = "set_sec";
        press_mode();
        press_inc(30);
        cur = "exit";
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // 5: MODE+INC same cycle, MODE+TICK in RUN
        cur = "mode_inc";
        press_mode();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        press_mode();
        press_mode();
        cur = "mode_tick";
        ticks(59);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        press_mode();
        press_mode();
        press_mode();

        // 6: reset asserted mid-rollover
        cur = "to_235959";
        press_mode();
        press_inc(22);
        press_mode();
        press_inc(58);
        press_mode();
        press_mode();
        ticks(59);
        TICK_1HZ = 1'b1;
        @(negedge CLK);
        RESETN = 1'b0;
        #1;
        model_reset();
        check_zero("rst_async");
        @(posedge CLK);
        #1;
        check_zero("rst_hold");
        TICK_1HZ = 1'b0;
        MODE_KEY = 1'b0;
        RESETN   = 1'b1;
        cur = "post_reset";
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
